// File: rtl/prime_sieve_engine.sv
// prime_sieve_engine: Eratosthenes sieve over 0..max_prime, compacted into a readable prime list
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   max_prime                inclusive sieve limit, latched on START
//   user_prime_ram_address   prime list index for readback
//   get_prime                readback strobe, honoured only while finished
//   calculate                start request, sampled in IDLE and DONE
//   finished                 prime list valid and engine idle
//   prime_ram_q              registered readback data (0 past the end of the list)
module prime_sieve_engine (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] max_prime,
  input  logic [7:0] user_prime_ram_address,
  input  logic       get_prime,
  input  logic       calculate,
  output logic       finished,
  output logic [9:0] prime_ram_q
);
  typedef enum logic [2:0] {IDLE, START, CALC, POPULATE, DONE} state_t;
  state_t state_q, state_d;
  logic [1023:0] bits_q;
  logic [9:0] list_q [256];
  logic [9:0] max_r_q, max_r_d, pi_q, pi_d, prime_ram_d;
  logic [5:0] sqrt_q, sqrt_d, p_q, p_d;
  logic [10:0] m_q, m_d, m_nxt, i_q, i_d;
  logic [7:0] cnt_q, cnt_d;
  logic mark_q, mark_d, pv_q, pv_d, rd_q, bit_we, list_we;
  function automatic logic [5:0] isqrt(input logic [9:0] v);
    logic [5:0] r;
    r = '0;
    for (int k = 1; k < 32; k++)
      if (11'(k * k) <= {1'b0, v}) r = 6'(k);
    return r;
  endfunction
  assign finished = state_q == DONE;
  // 11-bit sum: one spare bit catches overflow past 1023 instead of wrapping
  assign m_nxt = m_q + {5'd0, p_q};
  always_comb begin
    state_d = state_q;
    max_r_d = max_r_q;
    sqrt_d = sqrt_q;
    p_d = p_q;
    m_d = m_q;
    mark_d = mark_q;
    i_d = i_q;
    pi_d = pi_q;
    pv_d = pv_q;
    cnt_d = cnt_q;
    bit_we = 1'b0;
    list_we = 1'b0;
    prime_ram_d = prime_ram_q;
    unique case (state_q)
      IDLE: state_d = calculate ? START : IDLE;
      START: begin
        max_r_d = max_prime;
        sqrt_d = isqrt(max_prime);
        p_d = 6'd2;
        mark_d = 1'b0;
        i_d = 11'd2;
        pv_d = 1'b0;
        cnt_d = '0;
        state_d = CALC;
      end
      CALC: begin
        // mark_q: striking multiples of p_q, one write per cycle starting at p*p
        if (mark_q) begin
          bit_we = 1'b1;
          m_d = m_nxt;
          if (m_nxt > {1'b0, max_r_q}) begin
            mark_d = 1'b0;
            p_d = p_q + 6'd1;
          end
        end else if (p_q > sqrt_q) state_d = POPULATE;
        else if (bits_q[{4'd0, p_q}]) p_d = p_q + 6'd1;
        else begin
          mark_d = 1'b1;
          m_d = {5'd0, p_q} * {5'd0, p_q};
        end
      end
      POPULATE: begin
        // rd_q holds the bit for pi_q one cycle after its address was issued
        if (pv_q && !rd_q) begin
          list_we = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
        if (i_q <= {1'b0, max_r_q}) begin
          pi_d = i_q[9:0];
          pv_d = 1'b1;
          i_d = i_q + 11'd1;
        end else begin
          pv_d = 1'b0;
          state_d = pv_q ? POPULATE : DONE;
        end
      end
      DONE: begin
        state_d = (calculate && max_prime != max_r_q) ? START : DONE;
        if (get_prime)
          prime_ram_d = user_prime_ram_address < cnt_q ? list_q[user_prime_ram_address] : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      bits_q <= '0;
      max_r_q <= '0;
      sqrt_q <= '0;
      p_q <= '0;
      m_q <= '0;
      mark_q <= 1'b0;
      i_q <= '0;
      pi_q <= '0;
      pv_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
      prime_ram_q <= '0;
    end else begin
      state_q <= state_d;
      if (bit_we) bits_q[m_q[9:0]] <= 1'b1;
      max_r_q <= max_r_d;
      sqrt_q <= sqrt_d;
      p_q <= p_d;
      m_q <= m_d;
      mark_q <= mark_d;
      i_q <= i_d;
      pi_q <= pi_d;
      pv_q <= pv_d;
      rd_q <= bits_q[i_q[9:0]];
      cnt_q <= cnt_d;
      prime_ram_q <= prime_ram_d;
    end
  always_ff @(posedge clk)
    if (list_we) list_q[cnt_q] <= pi_q;
endmodule

// File: tb/tb_prime_sieve_engine.sv
// tb_prime_sieve_engine: table, corner-case and randomized checks of prime_sieve_engine
module tb_prime_sieve_engine;
  logic clk = 1'b0, reset_n = 1'b0, get_prime = 1'b0, calculate = 1'b0, finished;
  logic [9:0] max_prime = '0, prime_ram_q;
  logic [7:0] addr = '0;
  int tests = 0, fails = 0, cur = -1, v;
  typedef struct {int mp; int idx; int exp;} vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  prime_sieve_engine dut (
    .clk(clk),
    .reset_n(reset_n),
    .max_prime(max_prime),
    .user_prime_ram_address(addr),
    .get_prime(get_prime),
    .calculate(calculate),
    .finished(finished),
    .prime_ram_q(prime_ram_q)
  );
  function automatic int ref_prime(int lim, int idx);
    int n = 0;
    for (int x = 2; x <= lim; x++) begin
      bit p = 1'b1;
      for (int d = 2; d * d <= x; d++) if (x % d == 0) p = 1'b0;
      if (p) begin
        if (n == idx) return x;
        n++;
      end
    end
    return 0;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse(input int mp);
    @(negedge clk);
    max_prime = mp[9:0];
    calculate = 1'b1;
    @(negedge clk);
    calculate = 1'b0;
  endtask
  task automatic wait_done();
    int c = 0;
    while (!finished && c < 4096) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", int'(finished), 1);
  endtask
  task automatic run(input int mp);
    pulse(mp);
    chk("finished_drop", int'(finished), 0);
    wait_done();
    cur = mp;
  endtask
  task automatic rd(input int idx, output int val);
    @(negedge clk);
    addr = idx[7:0];
    get_prime = 1'b1;
    @(negedge clk);
    get_prime = 1'b0;
    val = int'(prime_ram_q);
  endtask
  initial begin
    tbl = '{'{100, 11, 37}, '{100, 0, 2}, '{100, 24, 97}, '{100, 25, 0},
            '{500, 57, 271}, '{500, 94, 499}, '{500, 95, 0},
            '{30, 9, 29}, '{30, 10, 0},
            '{1023, 171, 1021}, '{1023, 172, 0}, '{1023, 0, 2}};
    repeat (3) @(negedge clk);
    chk("reset_finished", int'(finished), 0);
    chk("reset_q", int'(prime_ram_q), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].mp != cur) run(tbl[i].mp);
      rd(tbl[i].idx, v);
      chk($sformatf("tbl%0d_lim%0d_idx%0d", i, tbl[i].mp, tbl[i].idx), v, tbl[i].exp);
    end
    pulse(1023);
    for (int i = 0; i < 3; i++) begin
      chk("same_limit_stays_finished", int'(finished), 1);
      @(negedge clk);
    end
    rd(171, v);
    chk("same_limit_list", v, 1021);
    pulse(100);
    addr = 8'd0;
    get_prime = 1'b1;
    @(negedge clk);
    get_prime = 1'b0;
    chk("get_while_busy", int'(prime_ram_q), 1021);
    max_prime = 10'd200;
    calculate = 1'b1;
    @(negedge clk);
    calculate = 1'b0;
    wait_done();
    cur = 100;
    rd(24, v);
    chk("calc_ignored_idx24", v, 97);
    rd(25, v);
    chk("calc_ignored_idx25", v, 0);
    pulse(500);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_finished", int'(finished), 0);
    chk("midrun_reset_q", int'(prime_ram_q), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(100);
    rd(11, v);
    chk("after_reset_idx11", v, 37);
    for (int r = 0; r < 6; r++) begin
      int mp;
      mp = r == 0 ? 1 : r == 1 ? 2 : int'($urandom_range(0, 1023));
      if (mp == cur) mp = (mp + 1) % 1024;
      run(mp);
      for (int k = 0; k < 5; k++) begin
        int idx;
        idx = k == 0 ? 0 : int'($urandom_range(0, 180));
        rd(idx, v);
        chk($sformatf("rand_lim%0d_idx%0d", mp, idx), v, ref_prime(mp, idx));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prime_sieve_engine.md
Name: prime_sieve_engine

Overview:
Self-contained prime generator. On a user `calculate` request it runs a Sieve of Eratosthenes over 0..max_prime, marking composites in an internal 1024x1 boolean memory. It then compacts the surviving primes, in ascending order, into an internal 256x10 prime list. Once finished, the user reads any prime by list index.

Parameters:
None. Widths are fixed: values are 10-bit, list index is 8-bit, sqrt bound is 6-bit.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
max_prime  input  10  inclusive upper limit for the sieve
user_prime_ram_address  input  8  index into the prime list for readback
get_prime  input  1  readback strobe; honoured only while finished=1
calculate  input  1  start request; sampled every cycle
finished  output  1  high when the prime list is valid and idle
prime_ram_q  output  10  registered readback data

Behaviour:
Reset (async, reset_n=0):
- finished=0, prime_ram_q=0, latched limit max_prime_r=0, prime_count=0.
- All boolean-memory bits cleared to 0 (0 = prime candidate, 1 = composite).
- FSM goes to IDLE.

Controller FSM states and transitions:
- IDLE -> START when calculate=1.
- START (1 cycle):
  - Latch max_prime_r <= max_prime.
  - Compute sqrt_bound = floor(sqrt(max_prime)) via 1024-entry lookup or equivalent combinational logic.
  - Go to CALC.
- CALC: sieve.
  - For p = 2..sqrt_bound: if bit[p]==0, write 1 to bit[m] for m = p*p, p*p+p, ... while m <= max_prime_r.
  - At most one boolean write per cycle; use 10-bit arithmetic plus carry detection so m never wraps past 1023.
  - When p > sqrt_bound, go to POPULATE.
- POPULATE: scan i = 2..max_prime_r.
  - Boolean memory has a 1-cycle synchronous read.
  - For each i with bit[i]==0, write i into prime list at index prime_count, then increment prime_count.
  - After i = max_prime_r is processed, go to DONE.
- DONE: finished=1.
  - calculate=1 with max_prime != max_prime_r -> START, and finished drops the next cycle.
  - calculate=1 with max_prime == max_prime_r -> stay in DONE; no recompute.

Design rules:
- Composite marks are never cleared between runs. They are bound-independent, so a larger or smaller rerun stays correct.
- prime_count restarts at 0 on each START.
- calculate is ignored in START, CALC and POPULATE.
- max_prime < 2 -> CALC and POPULATE are trivial; prime_count=0; finished asserts.
- Maximum list size is 172 primes (limit 1023); never exceeds 256 entries.

Readback:
- While finished=1 and get_prime=1, at the next rising edge prime_ram_q <= list[user_prime_ram_address].
- If the index is >= prime_count, prime_ram_q <= 0.
- When get_prime=0 or finished=0, prime_ram_q holds its value.

Latency:
- Unconstrained, but bounded.
- CALC takes one cycle per tested p plus one cycle per composite write.
- POPULATE takes max_prime_r + O(1) cycles.
- Total must be below 4096 cycles for limit 1023.

Reset mid-operation:
- Immediately aborts to IDLE with the reset values listed above.
- Boolean memory is cleared.

Test Plan:
- Reset, then max_prime=100, calculate pulsed 1 cycle -> finished rises within 4096 cycles; get_prime, index 11 -> prime_ram_q=37 on the next edge; index 0 -> 2; index 24 -> 97; index 25 -> 0.
- After the 100 run: max_prime=500, calculate pulse -> finished drops next cycle, then re-rises; index 57 -> 271; index 94 -> 499; index 95 -> 0.
- max_prime=1023 -> index 171 = 1021; index 172 -> 0.
- Shrink case: after the 500 run, run with max_prime=30 -> index 9 = 29; index 10 -> 0 (no stale entries visible).
- calculate with unchanged max_prime while finished -> finished stays 1, list unchanged. calculate during CALC -> ignored. get_prime while finished=0 -> prime_ram_q unchanged.
- Assert reset_n low during CALC -> finished=0 and prime_ram_q=0 immediately; a subsequent max_prime=100 run yields index 11 = 37.
